// File: rtl/game_pkg.sv
// Shared definitions for the game timer bank: channel states and mode encodings.
package game_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clk tick every DIV cycles.
module tick_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tick_q, tick_d;

  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    // tick is a flop that mirrors "counter holds LAST", so it is high in exactly that cycle
    tick_d = (cnt_d == LAST);
  end

  // NOTE: reset is synchronous here, so it sits inside the clocked branch and is sampled on the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/game_timer_bank.sv
// Bank of independent down-counting game timers driven by one shared tick prescaler.
module game_timer_bank
  import game_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] load_value,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH-1:0]       expire,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic                    tick
);

  logic tick_w;

  tick_prescaler #(.DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_w)
  );

  assign tick = tick_w;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             expire_q, expire_d;

    // Priority chain: load > stop (RUN only) > start (non-RUN only) > tick (RUN only).
    always_comb begin
      // NOTE: every signal gets its hold value first so no path through the ifs can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      expire_d = 1'b0;
      if (load[ch]) begin
        cnt_d    = load_value[ch*CNT_W +: CNT_W];
        reload_d = load_value[ch*CNT_W +: CNT_W];
        mode_d   = mode[ch];
        state_d  = ST_IDLE;
      end else if (stop[ch] && state_q == ST_RUN) begin
        state_d = ST_PAUSED;
      end else if (start[ch] && state_q != ST_RUN) begin
        state_d = ST_RUN;
        if (state_q == ST_DONE) cnt_d = reload_q;
      end else if (tick_w && state_q == ST_RUN) begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          expire_d = 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            cnt_d = reload_q;
          end else begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end
        end
      end
    end

    // NOTE: state flops use non-blocking assignments so all channels update from the same pre-edge values.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        reload_q <= '0;
        mode_q   <= MODE_ONESHOT;
        expire_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        reload_q <= reload_d;
        mode_q   <= mode_d;
        expire_q <= expire_d;
      end
    end

    assign running[ch]                = (state_q == ST_RUN);
    assign done[ch]                   = (state_q == ST_DONE);
    assign expire[ch]                 = expire_q;
    assign count[ch*CNT_W +: CNT_W]   = cnt_q;
  end

endmodule
